// File: rtl/fetch_target_queue.sv
// Fetch target queue: a circular buffer of fetch groups (PC + slot mask) between NextPC and Fetch.
// Define FETCH_TARGET_QUEUE_BYPASS_EN to forward an incoming group straight to the output when the queue is empty.
module fetch_target_queue #(
  parameter int unsigned DEPTH       = 4,
  parameter int unsigned FETCH_WIDTH = 2,
  parameter int unsigned PC_WIDTH    = 32
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     enq_valid,
  output logic                     enq_ready,
  input  logic [PC_WIDTH-1:0]      enq_pc,
  input  logic [FETCH_WIDTH-1:0]   enq_mask,
  output logic                     deq_valid,
  input  logic                     deq_ready,
  output logic [PC_WIDTH-1:0]      deq_pc,
  output logic [FETCH_WIDTH-1:0]   deq_mask,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     almost_full
);

  localparam int unsigned IdxW = $clog2(DEPTH);
  localparam int unsigned PtrW = IdxW + 1;

  logic [PC_WIDTH-1:0]    pcMem   [DEPTH];
  logic [FETCH_WIDTH-1:0] maskMem [DEPTH];

  // Pointers carry one extra wrap bit above the index.
  logic [PtrW-1:0] headPtr;
  logic [PtrW-1:0] tailPtr;
  logic [IdxW-1:0] headIdx;
  logic [IdxW-1:0] tailIdx;
  logic            empty;
  logic            full;
  logic            enqFire;
  logic            deqFire;

  assign headIdx = headPtr[IdxW-1:0];
  assign tailIdx = tailPtr[IdxW-1:0];
  assign empty   = (headPtr == tailPtr);
  assign full    = (headIdx == tailIdx) && (headPtr[IdxW] != tailPtr[IdxW]);

  assign enq_ready   = !full && !flush;
  assign count       = tailPtr - headPtr;
  assign almost_full = (count >= PtrW'(DEPTH - 1));

`ifdef FETCH_TARGET_QUEUE_BYPASS_EN
  logic bypassHit;

  // Empty queue with a live incoming group: present it directly.
  assign bypassHit = empty && !flush && enq_valid;
  assign deq_valid = (!empty && !flush) || bypassHit;
  assign deq_pc    = empty ? enq_pc   : pcMem[headIdx];
  assign deq_mask  = empty ? enq_mask : maskMem[headIdx];
  assign enqFire   = enq_valid && enq_ready && !(bypassHit && deq_ready);
  assign deqFire   = deq_valid && deq_ready && !empty;
`else
  assign deq_valid = !empty && !flush;
  assign deq_pc    = pcMem[headIdx];
  assign deq_mask  = maskMem[headIdx];
  assign enqFire   = enq_valid && enq_ready;
  assign deqFire   = deq_valid && deq_ready;
`endif

  // Pointer update; natural overflow wraps the index and toggles the wrap bit.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      headPtr <= '0;
      tailPtr <= '0;
    end else if (flush) begin
      headPtr <= '0;
      tailPtr <= '0;
    end else begin
      if (enqFire) tailPtr <= tailPtr + PtrW'(1);
      if (deqFire) headPtr <= headPtr + PtrW'(1);
    end
  end

  // Entry storage needs no reset; validity comes from the pointers.
  always_ff @(posedge clk) begin
    if (enqFire) begin
      pcMem[tailIdx]   <= enq_pc;
      maskMem[tailIdx] <= enq_mask;
    end
  end

endmodule
